// File: rtl/program_loader.sv
// Switch-panel program loader: synchronises a load switch and a write button,
// writes bytes into program memory, then starts and supervises the computer.
module program_loader #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [DW-1:0] in_data,
    input  logic          in_strobe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_start,
    input  logic          cpu_halt,
    output logic [1:0]    state,
    output logic [AW:0]   load_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        HALT = 2'b11
    } state_e;

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    state_e        state_q;
    logic          len_s1_q;
    logic          len_s2_q;
    logic          stb_s1_q;
    logic          stb_s2_q;
    logic          stb_hist_q;
    logic          vld1_q;
    logic          vld2_q;
    logic          armed_q;
    logic          pend_q;
    logic [DW-1:0] data_q;
    logic [AW:0]   cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          start_q;

    logic          stb_evt;
    logic [AW+1:0] fill;
    logic          accept;

    // A strobe only counts once the synchroniser has seen the button
    // released after reset, so a button held through reset cannot write.
    assign stb_evt = stb_s2_q & ~stb_hist_q & armed_q;
    assign fill    = {1'b0, cnt_q} + {{(AW+1){1'b0}}, pend_q};
    assign accept  = stb_evt && (state_q == LOAD) && (fill < {1'b0, FULL});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_s1_q   <= 1'b0;
            len_s2_q   <= 1'b0;
            stb_s1_q   <= 1'b0;
            stb_s2_q   <= 1'b0;
            stb_hist_q <= 1'b0;
            vld1_q     <= 1'b0;
            vld2_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            len_s1_q   <= load_en;
            len_s2_q   <= len_s1_q;
            stb_s1_q   <= in_strobe;
            stb_s2_q   <= stb_s1_q;
            stb_hist_q <= stb_s2_q;
            vld1_q     <= 1'b1;
            vld2_q     <= vld1_q;
            armed_q    <= armed_q | (vld2_q & ~stb_s2_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            pend_q <= accept;
            if (accept) begin
                data_q <= in_data;
            end
            unique case (state_q)
                IDLE: begin
                    start_q <= 1'b0;
                    if (len_s2_q) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                    end
                end
                LOAD: begin
                    // A pending write always finishes before any exit
                    if (pend_q) begin
                        we_q    <= 1'b1;
                        addr_q  <= cnt_q[AW-1:0];
                        wdata_q <= data_q;
                        cnt_q   <= cnt_q + 1'b1;
                    end else if (cnt_q == FULL) begin
                        state_q <= RUN;
                        start_q <= 1'b1;
                        addr_q  <= '0;
                    end else if (!len_s2_q && !accept) begin
                        addr_q <= '0;
                        if (cnt_q != '0) begin
                            state_q <= RUN;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                RUN: begin
                    addr_q <= '0;
                    if (cpu_halt) begin
                        state_q <= HALT;
                        start_q <= 1'b0;
                    end
                end
                HALT: begin
                    start_q <= 1'b0;
                    if (len_s2_q) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign load_count = cnt_q;
    assign mem_addr   = addr_q;
    assign mem_we     = we_q;
    assign mem_wdata  = wdata_q;
    assign cpu_start  = start_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, run, halt, reload, overflow,
// aborts and strobe timing.
module tb_program_loader;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_en;
    logic [DW-1:0] in_data;
    logic          in_strobe;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          cpu_start;
    logic          cpu_halt;
    logic [1:0]    state;
    logic [AW:0]   load_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } vec_t;

    vec_t vecs[3];

    program_loader #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (load_en),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .cpu_start (cpu_start),
        .cpu_halt  (cpu_halt),
        .state     (state),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input string name, input logic [AW-1:0] a,
                                input logic [DW-1:0] d);
        if (wa_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no write expected addr %0h data %0h",
                     name, a, d);
        end else begin
            chk({name, "_addr"}, 32'(wa_q.pop_front()), 32'(a));
            chk({name, "_data"}, 32'(wd_q.pop_front()), 32'(d));
        end
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        in_data   = d;
        in_strobe = 1'b1;
        repeat (4) @(negedge clk);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic halt_pulse();
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_state"}, 32'(state), 32'd0);
        chk({name, "_start"}, 32'(cpu_start), 32'd0);
        chk({name, "_we"}, 32'(mem_we), 32'd0);
        chk({name, "_cnt"}, 32'(load_count), 32'd0);
        chk({name, "_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        int pulses;
        int at;
        vecs[0] = '{data: 8'hA1, addr: 5'd0};
        vecs[1] = '{data: 8'h02, addr: 5'd1};
        vecs[2] = '{data: 8'h33, addr: 5'd2};

        rst_n     = 1'b0;
        load_en   = 1'b0;
        in_data   = '0;
        in_strobe = 1'b0;
        cpu_halt  = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", 32'(state), 32'd0);

        // basic load of three bytes then run
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("enter_load", 32'(state), 32'd1);
        chk("enter_load_cnt", 32'(load_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            strobe(vecs[i].data);
            expect_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
        end
        chk("vec_no_extra", 32'(wa_q.size()), 32'd0);
        load_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("run_state", 32'(state), 32'd2);
        chk("run_start", 32'(cpu_start), 32'd1);
        chk("run_cnt", 32'(load_count), 32'd3);
        chk("run_addr", 32'(mem_addr), 32'd0);

        // halt, reload one byte
        halt_pulse();
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_start", 32'(cpu_start), 32'd0);
        chk("halt_cnt_hold", 32'(load_count), 32'd3);
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("reload_state", 32'(state), 32'd1);
        chk("reload_cnt", 32'(load_count), 32'd0);
        strobe(8'h5C);
        expect_write("reload", 5'd0, 8'h5C);

        // strobe held 20 cycles: one pulse on the 4th edge
        pulses    = 0;
        at        = 0;
        in_data   = 8'h6B;
        in_strobe = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                pulses++;
                at = k;
            end
        end
        in_strobe = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_latency", 32'(at), 32'd4);
        expect_write("held", 5'd1, 8'h6B);
        repeat (4) @(negedge clk);
        load_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("run2_state", 32'(state), 32'd2);
        chk("run2_cnt", 32'(load_count), 32'd2);

        // full memory load, 33rd strobe ignored
        halt_pulse();
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_load_state", 32'(state), 32'd1);
        for (int i = 0; i < 33; i++) begin
            strobe(8'(i));
        end
        chk("full_writes", 32'(wa_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            expect_write($sformatf("full%0d", i), 5'(i), 8'(i));
        end
        chk("full_state", 32'(state), 32'd2);
        chk("full_cnt", 32'(load_count), 32'd32);
        chk("full_start", 32'(cpu_start), 32'd1);

        // halt with load_en high reloads; zero-write exit goes to IDLE
        halt_pulse();
        chk("halt2_state", 32'(state), 32'd3);
        repeat (2) @(negedge clk);
        chk("halt2_reload", 32'(state), 32'd1);
        load_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("empty_idle", 32'(state), 32'd0);
        chk("empty_start", 32'(cpu_start), 32'd0);
        chk("empty_cnt", 32'(load_count), 32'd0);
        strobe(8'hEE);
        chk("idle_strobe", 32'(wa_q.size()), 32'd0);
        chk("idle_strobe_state", 32'(state), 32'd0);

        // strobe and load_en fall together: write completes, then RUN
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("race_load", 32'(state), 32'd1);
        in_data   = 8'h77;
        in_strobe = 1'b1;
        load_en   = 1'b0;
        repeat (10) @(negedge clk);
        in_strobe = 1'b0;
        expect_write("race", 5'd0, 8'h77);
        chk("race_state", 32'(state), 32'd2);
        chk("race_cnt", 32'(load_count), 32'd1);

        // reset one cycle after a strobe event aborts the write
        halt_pulse();
        load_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_load", 32'(state), 32'd1);
        in_data   = 8'h99;
        in_strobe = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) @(negedge clk);
        chk("abort_no_we", 32'(wa_q.size()), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'(state), 32'd0);
        repeat (12) @(negedge clk);
        chk("held_reset_no_write", 32'(wa_q.size()), 32'd0);
        chk("held_reset_load", 32'(state), 32'd1);
        chk("held_reset_cnt", 32'(load_count), 32'd0);
        in_strobe = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
